// File: rtl/data_sram_like_slave_if.sv
// rtl/data_sram_like_slave_if.sv - SRAM-like req/addr_ok/data_ok data-side port bundle
interface data_sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_like_slave.sv
// rtl/data_sram_like_slave.sv - data-side SRAM-like responder with fixed-latency in-order responses
// Optional alignment/strobe checking is enabled by defining SRAM_SLAVE_ALIGN_CHECK_EN.
module data_sram_like_slave #(
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    data_sram_like_slave_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCC_W-1:0] MAX_OCC  = OCC_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [3:0]       LAT_INIT = 4'(LATENCY);

    logic [31:0] mem_q [DEPTH];

    logic [31:0]      rsp_data_q [MAX_OUTSTANDING];
    logic [31:0]      rsp_data_d [MAX_OUTSTANDING];
    logic [3:0]       rsp_cnt_q  [MAX_OUTSTANDING];
    logic [3:0]       rsp_cnt_d  [MAX_OUTSTANDING];
    logic             rsp_vld_q  [MAX_OUTSTANDING];
    logic             rsp_vld_d  [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             err_q, err_d;

    logic [DEPTH_LOG2-1:0] widx;
    logic                  req_err;
    logic                  accept;
    logic                  rsp_fire;
    logic                  slot_free;
    logic                  mem_we;

    assign widx = bus.addr[DEPTH_LOG2+1:2];

    // The head entry answers once its countdown reaches 1; entries behind it
    // were accepted later, so in-order release is automatic.
    assign rsp_fire  = !reset && rsp_vld_q[head_q] && (rsp_cnt_q[head_q] == 4'd1);
    assign slot_free = (occ_q < MAX_OCC) || rsp_fire;
    assign accept    = bus.req && !reset && slot_free;
    assign mem_we    = accept && bus.wr && !req_err;

    assign bus.addr_ok = accept;
    assign bus.data_ok = rsp_fire;
    assign bus.rdata   = rsp_fire ? rsp_data_q[head_q] : 32'd0;

`ifdef SRAM_SLAVE_ALIGN_CHECK_EN
    logic [3:0] lane_mask;

    always_comb begin
        lane_mask = 4'b1111;
        case (bus.size)
            2'd0:    lane_mask = 4'b0001 << bus.addr[1:0];
            2'd1:    lane_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        req_err = (bus.size == 2'd3)
               || ((bus.size == 2'd1) && bus.addr[0])
               || ((bus.size == 2'd2) && (bus.addr[1:0] != 2'd0))
               || (bus.wr && |(bus.wstrb & ~lane_mask));
    end

    assign bus.err = err_q;
`else
    logic unused_chk;

    assign req_err    = 1'b0;
    assign bus.err    = 1'b0;
    assign unused_chk = ^{bus.size, bus.addr[1:0], err_q};
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:DEPTH_LOG2+2];

    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            rsp_data_d[i] = rsp_data_q[i];
            rsp_vld_d[i]  = rsp_vld_q[i];
            rsp_cnt_d[i]  = rsp_cnt_q[i];
            if (rsp_vld_q[i] && (rsp_cnt_q[i] > 4'd1)) begin
                rsp_cnt_d[i] = rsp_cnt_q[i] - 4'd1;
            end
        end
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        err_d  = err_q | (accept && req_err);

        if (rsp_fire) begin
            rsp_vld_d[head_q] = 1'b0;
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
        end

        // Push after pop: when full, head and tail alias and the new entry must win.
        if (accept) begin
            rsp_vld_d[tail_q]  = 1'b1;
            rsp_cnt_d[tail_q]  = LAT_INIT;
            rsp_data_d[tail_q] = (bus.wr || req_err) ? 32'd0 : mem_q[widx];
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
        end

        case ({accept, rsp_fire})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                rsp_data_q[i] <= 32'd0;
                rsp_cnt_q[i]  <= 4'd0;
                rsp_vld_q[i]  <= 1'b0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                rsp_data_q[i] <= rsp_data_d[i];
                rsp_cnt_q[i]  <= rsp_cnt_d[i];
                rsp_vld_q[i]  <= rsp_vld_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem_q[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_like_slave.sv
// tb/tb_data_sram_like_slave.sv - scoreboard bench for data_sram_like_slave (two latency/outstanding configs)
module tb_data_sram_like_slave;
`ifdef SRAM_SLAVE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          sel;

    int          cyc;
    int          checks;
    int          errors;
    rsp_t        q[$];
    logic [31:0] mdl [int];
    bit          err_mdl [2];

    data_sram_like_slave_if bus_a();
    data_sram_like_slave_if bus_b();

    assign bus_a.req   = req && !sel;
    assign bus_a.wr    = wr;
    assign bus_a.size  = size;
    assign bus_a.addr  = addr;
    assign bus_a.wstrb = wstrb;
    assign bus_a.wdata = wdata;
    assign bus_b.req   = req && sel;
    assign bus_b.wr    = wr;
    assign bus_b.size  = size;
    assign bus_b.addr  = addr;
    assign bus_b.wstrb = wstrb;
    assign bus_b.wdata = wdata;

    data_sram_like_slave #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_OUTSTANDING(4)) dut_a (
        .clk(clk), .reset(rst), .bus(bus_a)
    );
    data_sram_like_slave #(.DEPTH_LOG2(10), .LATENCY(4), .MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .reset(rst), .bus(bus_b)
    );

    logic        o_addr_ok, o_data_ok, o_err;
    logic [31:0] o_rdata;
    assign o_addr_ok = sel ? bus_b.addr_ok : bus_a.addr_ok;
    assign o_data_ok = sel ? bus_b.data_ok : bus_a.data_ok;
    assign o_rdata   = sel ? bus_b.rdata   : bus_a.rdata;
    assign o_err     = sel ? bus_b.err     : bus_a.err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit is_bad(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [3:0] st);
        int nbytes;
        int off;
        if (sz == 2'd3) return 1'b1;
        nbytes = 1 << sz;
        off = int'(a[1:0]);
        if ((off % nbytes) != 0) return 1'b1;
        if (w && sz != 2'd2) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b] && (b < off || b >= off + nbytes)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Scoreboard monitor: addr_ok expectation from model occupancy, responses from the queue.
    always @(negedge clk) begin
        int   mx;
        bit   exp_dok;
        bit   exp_aok;
        rsp_t e;
        mx = sel ? 2 : 4;
        if (rst) begin
            chk(o_addr_ok === 1'b0, "rst_addr_ok", {31'd0, o_addr_ok}, 32'd0);
            chk(o_data_ok === 1'b0, "rst_data_ok", {31'd0, o_data_ok}, 32'd0);
            chk(o_rdata === 32'd0, "rst_rdata", o_rdata, 32'd0);
            q.delete();
            err_mdl[0] = 1'b0;
            err_mdl[1] = 1'b0;
        end else begin
            exp_dok = (q.size() > 0) && (q[0].due == cyc);
            exp_aok = req && ((q.size() < mx) || exp_dok);
            chk(o_addr_ok === exp_aok, "addr_ok", {31'd0, o_addr_ok}, {31'd0, exp_aok});
            chk(o_data_ok === exp_dok, "data_ok", {31'd0, o_data_ok}, {31'd0, exp_dok});
            if (exp_dok) begin
                e = q.pop_front();
                chk(o_rdata === e.data, "rdata", o_rdata, e.data);
            end else begin
                chk(o_rdata === 32'd0, "rdata_idle", o_rdata, 32'd0);
            end
            chk(o_err === err_mdl[sel], "err", {31'd0, o_err}, {31'd0, err_mdl[sel]});
        end
    end

    task automatic model_accept();
        int          key;
        int          lat;
        bit          bad;
        logic [31:0] d;
        lat = sel ? 4 : 2;
        key = int'(sel) * 1024 + int'(addr[11:2]);
        bad = ALIGN && is_bad(wr, size, addr, wstrb);
        d   = 32'd0;
        if (!wr) begin
            if (!bad) d = mdl[key];
        end else if (!bad) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mdl[key][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (bad) err_mdl[sel] = 1'b1;
        q.push_back('{cyc + lat, d});
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [3:0] st, input logic [31:0] d);
        int waited;
        bit done;
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            #1;
            if (o_addr_ok) begin
                model_accept();
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 32) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout at cycle %0d: got no addr_ok expected accept", cyc);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic init_words();
        for (int w = 0; w < 16; w++) do_req(1'b1, 2'd2, 32'(w * 4), 4'hF, $urandom);
        idle(6);
    endtask

    task automatic random_ops(input int n);
        logic [1:0]  sz;
        logic [31:0] a;
        logic [3:0]  st;
        int          off;
        for (int i = 0; i < n; i++) begin
            sz = 2'($urandom_range(0, 2));
            off = (sz == 2'd0) ? $urandom_range(0, 3) : (sz == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'(off);
            st = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) st = 4'h0;
            do_req(1'($urandom_range(0, 1)), sz, a, st, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(8);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        err_mdl[0] = 1'b0; err_mdl[1] = 1'b0;
        sel = 1'b0;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wstrb = 4'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Configuration A: LATENCY=2, MAX_OUTSTANDING=4
        init_words();
        do_req(1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
        idle(4);
        do_req(1'b1, 2'd2, 32'h20, 4'hF, 32'h11223344);
        do_req(1'b1, 2'd0, 32'h22, 4'b0100, 32'h00AA0000);
        do_req(1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) do_req(1'b0, 2'd2, 32'(i * 4), 4'h0, 32'h0);
        idle(4);
        random_ops(150);
        do_req(1'b1, 2'd2, 32'h24, 4'hF, 32'h5555AAAA);
        do_req(1'b1, 2'd2, 32'h22, 4'hF, 32'h12345678);
        do_req(1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
        do_req(1'b0, 2'd2, 32'h24, 4'h0, 32'h0);
        idle(6);

        // Configuration B: LATENCY=4, MAX_OUTSTANDING=2
        sel = 1'b1;
        idle(2);
        init_words();
        for (int i = 0; i < 6; i++) do_req(1'b0, 2'd2, 32'(i * 4), 4'h0, 32'h0);
        idle(8);
        random_ops(100);
        do_req(1'b1, 2'd2, 32'h14, 4'hF, 32'hCAFEF00D);
        do_req(1'b0, 2'd2, 32'h0C, 4'h0, 32'h0);
        do_req(1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
        rst = 1'b1;
        req = 1'b1; wr = 1'b1; addr = 32'h14; size = 2'd2; wstrb = 4'hF; wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        do_req(1'b0, 2'd2, 32'h14, 4'h0, 32'h0);
        idle(8);

        chk(q.size() == 0, "drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
